// File: rtl/cache_read_response_buffer_pkg.sv
// Shared widths and packet layout for the cache read-response path.
// The network response injector unpacks the same {dest, addr, data} layout.
package cache_read_response_buffer_pkg;

    localparam int DATA_W       = 32;
    localparam int NET_ADDR_W   = 4;
    localparam int BANK_ADDR_W  = 8;
    localparam int RESP_DEPTH   = 4;

    function automatic int resp_width(input int dw, input int nw, input int bw);
        return nw + bw + dw;
    endfunction

endpackage

// File: rtl/cache_read_response_buffer_response_fifo.sv
// Generic synchronous FIFO with count, full/empty flags and async reset.
// A pop frees the head slot in the same cycle, so push is accepted when full.
module response_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cache_read_response_buffer.sv
// Aligns an arbiter read grant with bank data one cycle later and queues
// the completed response for the network link with valid/ready handshake.
module cache_read_response_buffer
    import cache_read_response_buffer_pkg::*;
#(
    parameter int DATA_WIDTH               = DATA_W,
    parameter int NETWORK_ADDRESS_WIDTH    = NET_ADDR_W,
    parameter int CACHE_BANK_ADDRESS_WIDTH = BANK_ADDR_W,
    parameter int FIFO_DEPTH               = RESP_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                readReadyIn,
    input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
    input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheReadAddressIn,
    input  logic [DATA_WIDTH-1:0]               cacheDataIn,
    output logic                                respValid,
    input  logic                                respReady,
    output logic [NETWORK_ADDRESS_WIDTH-1:0]    respDest,
    output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] respAddr,
    output logic [DATA_WIDTH-1:0]               respData,
    output logic                                stallOut,
    output logic                                overflow
);

    localparam int RW = resp_width(DATA_WIDTH, NETWORK_ADDRESS_WIDTH,
                                   CACHE_BANK_ADDRESS_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                                pend_valid_q;
    logic [NETWORK_ADDRESS_WIDTH-1:0]    pend_dest_q;
    logic [CACHE_BANK_ADDRESS_WIDTH-1:0] pend_addr_q;
    logic                                overflow_q;
    logic                                overflow_d;

    logic [RW-1:0] fifo_wdata;
    logic [RW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign fifo_wdata = {pend_dest_q, pend_addr_q, cacheDataIn};
    assign pop        = respValid & respReady;

    response_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pend_valid_q),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign respValid = ~fifo_empty;
    assign {respDest, respAddr, respData} = fifo_rdata;

    // Leave one slot free for the grant that may already be in flight.
    assign stallOut = (fifo_count + CW'(pend_valid_q)) >= CW'(FIFO_DEPTH - 1);

    assign overflow_d = overflow_q | (pend_valid_q & fifo_full & ~pop);
    assign overflow   = overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_dest_q  <= '0;
            pend_addr_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            pend_valid_q <= readReadyIn;
            if (readReadyIn) begin
                pend_dest_q <= requesterAddressIn;
                pend_addr_q <= cacheReadAddressIn;
            end
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_cache_read_response_buffer.sv
// Randomized and directed scoreboard bench for cache_read_response_buffer.
module tb_cache_read_response_buffer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        readReadyIn = 1'b0;
    logic [3:0]  requesterAddressIn = '0;
    logic [7:0]  cacheReadAddressIn = '0;
    logic [31:0] cacheDataIn = '0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [3:0]  respDest;
    logic [7:0]  respAddr;
    logic [31:0] respData;
    logic        stallOut;
    logic        overflow;

    cache_read_response_buffer #(
        .DATA_WIDTH               (32),
        .NETWORK_ADDRESS_WIDTH    (4),
        .CACHE_BANK_ADDRESS_WIDTH (8),
        .FIFO_DEPTH               (D)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .readReadyIn        (readReadyIn),
        .requesterAddressIn (requesterAddressIn),
        .cacheReadAddressIn (cacheReadAddressIn),
        .cacheDataIn        (cacheDataIn),
        .respValid          (respValid),
        .respReady          (respReady),
        .respDest           (respDest),
        .respAddr           (respAddr),
        .respData           (respData),
        .stallOut           (stallOut),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [7:0]  addr;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    bit          m_pend;
    logic [3:0]  m_dest;
    logic [7:0]  m_addr;
    bit          m_ovf;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: a grant becomes a pending request; one cycle later it
    // joins the expected response queue with the data on the bus, or is lost
    // if the queue is full after any pop taken by the monitor that cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            if (m_pend) begin
                if (exp_q.size() < D)
                    exp_q.push_back('{m_dest, m_addr, cacheDataIn});
                else
                    m_ovf = 1;
            end
            m_pend = readReadyIn;
            m_dest = requesterAddressIn;
            m_addr = cacheReadAddressIn;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("respValid", 64'(respValid), 64'(exp_q.size() > 0));
            chk("stallOut", 64'(stallOut),
                64'((exp_q.size() + int'(m_pend)) >= D - 1));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (respValid && exp_q.size() > 0) begin
                chk("respDest", 64'(respDest), 64'(exp_q[0].dest));
                chk("respAddr", 64'(respAddr), 64'(exp_q[0].addr));
                chk("respData", 64'(respData), 64'(exp_q[0].data));
                if (respReady) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input bit rr, input logic [3:0] d, input logic [7:0] a,
                       input logic [31:0] data, input bit rdy);
        readReadyIn        = rr;
        requesterAddressIn = d;
        cacheReadAddressIn = a;
        cacheDataIn        = data;
        respReady          = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 8'h0, 32'h0, rdy);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        readReadyIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        readReadyIn = 1'b0;
        @(negedge clk);
        chk("reset_respDest", 64'(respDest), 64'h0);
        chk("reset_respAddr", 64'(respAddr), 64'h0);
        chk("reset_respData", 64'(respData), 64'h0);
        @(posedge clk);
        #1;

        // single read
        cyc(1, 4'h3, 8'h2, 32'h0, 1);
        cyc(0, 4'h0, 8'h0, 32'd10, 1);
        idle(3, 1);

        // back-to-back with backpressure
        cyc(1, 4'h1, 8'h1, 32'h0, 0);
        cyc(1, 4'h2, 8'h2, 32'd4, 0);
        cyc(1, 4'h3, 8'h3, 32'd5, 0);
        cyc(1, 4'h4, 8'h4, 32'd6, 0);
        cyc(0, 4'h0, 8'h0, 32'd7, 0);
        idle(2, 0);
        idle(6, 1);

        // hold under backpressure
        cyc(1, 4'h9, 8'h55, 32'h0, 0);
        cyc(0, 4'h0, 8'h0, 32'hDEADBEEF, 0);
        idle(5, 0);
        idle(3, 1);

        // full with simultaneous push and pop
        cyc(1, 4'h1, 8'h11, 32'h0, 0);
        cyc(1, 4'h2, 8'h12, 32'hA1, 0);
        cyc(1, 4'h3, 8'h13, 32'hA2, 0);
        cyc(1, 4'h4, 8'h14, 32'hA3, 0);
        cyc(1, 4'h5, 8'h15, 32'hA4, 0);
        cyc(0, 4'h0, 8'h0, 32'hA5, 1);
        idle(6, 1);

        // overflow: fifth grant dropped
        cyc(1, 4'h6, 8'h21, 32'h0, 0);
        cyc(1, 4'h7, 8'h22, 32'hB1, 0);
        cyc(1, 4'h8, 8'h23, 32'hB2, 0);
        cyc(1, 4'h9, 8'h24, 32'hB3, 0);
        cyc(1, 4'hA, 8'h25, 32'hB4, 0);
        cyc(0, 4'h0, 8'h0, 32'hB5, 0);
        idle(6, 1);

        // reset mid-operation: two queued, one pending
        cyc(1, 4'hC, 8'h31, 32'h0, 0);
        cyc(1, 4'hD, 8'h32, 32'hC1, 0);
        cyc(1, 4'hE, 8'h33, 32'hC2, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_respValid", 64'(respValid), 64'h0);
        chk("midreset_stallOut", 64'(stallOut), 64'h0);
        chk("midreset_overflow", 64'(overflow), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5, 1);

        // randomized traffic, mostly honoring stallOut
        for (int i = 0; i < 3000; i++) begin
            bit rr;
            rr = ($urandom_range(0, 3) != 0) &&
                 (!stallOut || ($urandom_range(0, 49) == 0));
            cyc(rr, 4'($urandom), 8'($urandom), $urandom,
                $urandom_range(0, 2) != 0);
        end
        idle(8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_read_response_buffer.md
Name: cache_read_response_buffer

Overview:
Per-direction read-response stage directly downstream of the cache access arbiter and its cache bank.
- Captures each read grant (readReady, requester address, cache address) and aligns it with the bank read data, which arrives one cycle later.
- Queues the completed response in a small FIFO and presents it to the network output link with a valid/ready handshake.
- One instance per direction: NORTH, SOUTH, EAST, WEST.

Parameters:
DATA_WIDTH, `DATA_WIDTH, width of cache data word
NETWORK_ADDRESS_WIDTH, `NETWORK_ADDRESS_WIDTH, width of requester network address
CACHE_BANK_ADDRESS_WIDTH, `CACHE_BANK_ADDRESS_WIDTH, width of cache bank address
FIFO_DEPTH, 4, response entries; power of two, >= 2

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
readReadyIn  in  1  arbiter read grant for this direction (cycle T)
requesterAddressIn  in  NETWORK_ADDRESS_WIDTH  arbiter requesterAddressOut, valid with readReadyIn
cacheReadAddressIn  in  CACHE_BANK_ADDRESS_WIDTH  arbiter cacheReadAddress for this port, valid with readReadyIn
cacheDataIn  in  DATA_WIDTH  bank dOut for this port, valid in cycle T+1
respValid  out  1  head FIFO entry available
respReady  in  1  network link accepts head entry this cycle
respDest  out  NETWORK_ADDRESS_WIDTH  destination (original requester)
respAddr  out  CACHE_BANK_ADDRESS_WIDTH  cache address of the response
respData  out  DATA_WIDTH  read data
stallOut  out  1  backpressure to arbiter: do not grant reads to this direction
overflow  out  1  sticky: a response was dropped

Behaviour:
- Reset (asynchronous): respValid=0, stallOut=0, overflow=0, respDest/respAddr/respData=0, FIFO count=0, pointers=0, pending stage empty. Reset asserted mid-operation discards all queued and pending responses. No partial packet is emitted after release.
- Stage 1 (pending):
  - At the posedge ending cycle T with readReadyIn=1, latch {requesterAddressIn, cacheReadAddressIn} and set pendingValid.
  - A new grant in T+1 overwrites the pending stage at the same edge its old contents commit. Back-to-back grants every cycle are supported.
- Stage 2 (commit): in cycle T+1 with pendingValid=1, write {pendingDest, pendingAddr, cacheDataIn} into the FIFO at the posedge ending T+1.
- Latency: grant in cycle T gives respValid=1 in cycle T+2 when the FIFO was empty. There is no bypass path.
- Output:
  - respDest/respAddr/respData always show the head entry and are held stable while respValid=1 and respReady=0.
  - Pop occurs on a posedge with respValid & respReady.
  - respReady while empty has no effect.
- Simultaneous push and pop: count unchanged. This is allowed when full, because the pop frees the slot for the push.
- Full:
  - A commit when count==FIFO_DEPTH with no pop in the same cycle drops the entry.
  - overflow is set and stays 1 until reset. FIFO contents are unchanged.
- stallOut (combinational from registered state) = (count + pendingValid) >= FIFO_DEPTH-1. It reserves room for one grant already in flight, so a compliant arbiter never causes overflow.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- readReadyIn during reset is ignored.

Decomposition:
- Response packet field widths and the packed layout {dest, addr, data} go into globalVariables.v as shared defines; the network response injector reuses them.
- One sub-module: response_fifo, a generic synchronous FIFO with width/depth parameters, push/pop, full/empty/count, and async active-high reset.
- The top level holds the pending stage, overflow, and stallOut logic.

Test Plan:
- Single read: grant T (dest=4'h3, addr=8'h2), cacheDataIn=10 in T+1, respReady=1 -> respValid=1 in T+2 with {3,2,10}; respValid=0 in T+3.
- Back-to-back: grants for addr 1,2,3,4 in consecutive cycles with data 4,5,6,7, respReady=0 -> stallOut rises once count+pending>=3. After respReady=1, entries pop in order addr1..4 with data 4..7.
- Hold under backpressure: respReady=0 for 5 cycles with one entry -> outputs stable and respValid=1 throughout; entry pops on the first cycle respReady=1.
- Overflow: ignore stallOut, keep respReady=0, issue 5 grants -> first 4 kept, 5th dropped, overflow=1 and stays set after draining.
- Full with push+pop: full FIFO, grant commits in the same cycle respReady=1 -> no drop, overflow=0, count remains 4, new entry at tail.
- Reset mid-operation: 2 entries queued plus 1 pending, reset asserted between edges -> respValid/stallOut/overflow drop immediately. After release, nothing is emitted until a new grant.
